hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the ID/EX register and observes that register's outputs: the EX-stage MemRead, rt and Jump fields, plus the branch-taken result. From these it drives the ID/EX flush input, the PC and IF/ID write enables, the IF/ID flush and a global hold for the back-end registers. It also freezes the pipeline while the data memory is not ready, and keeps saturating stall/flush statistics and a sticky memory-timeout error.

---
 rtl/hazard_defs.sv | 12 +
 rtl/sat_counter.sv | 24 ++
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_defs.sv
// Shared definitions for the pipeline hazard controller.
// Provides the controller state encoding and the default memory timeout.
package hazard_defs;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam int DEFAULT_MEM_TIMEOUT = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   - clock
//   clr   - synchronous clear (wins over inc)
//   inc   - count enable; holds at all-ones once reached
//   count - current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Watches the ID/EX register outputs and the data-memory handshake and
// drives the stall/flush/hold controls combinationally (Mealy), so a hazard
// seen in cycle N takes effect at the edge closing cycle N.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt - source operands of the instruction in ID
//   ex_memread, ex_rt, ex_jump, ex_branch_taken - EX-stage instruction info
//   mem_req, mem_ready     - data-memory access handshake of the MEM stage
//   pc_write, ifid_write   - front-end write enables
//   ifid_flush, idex_flush - bubble insertion
//   pipe_hold              - freezes EX/MEM and MEM/WB
//   stall_count, flush_count - saturating statistics
//   mem_err                - sticky memory-timeout flag
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; load-use and redirect handled per cycle
// MEM_WAIT | data access outstanding, whole pipeline frozen until ready
module hazard_ctrl
    import hazard_defs::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_jump,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_err
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    hz_state_t         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_wait, redirect, loaduse;
    logic              redirect_win;

    assign mem_wait = mem_req && !mem_ready;
    assign redirect = ex_jump || ex_branch_taken;
    assign loaduse  = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (wait_cnt_d == TIMEOUT_V) begin
                mem_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = '0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        pipe_hold    = 1'b0;
        redirect_win = 1'b0;

        if (mem_wait) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else if (redirect) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            redirect_win = 1'b1;
        end else if (loaduse) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end

        if (state_q == RUN) begin
            if (mem_wait) begin
                state_d = MEM_WAIT;
            end
        end else begin
            if (mem_wait) begin
                // Saturate at the timeout rather than wrapping.
                wait_cnt_d = (wait_cnt_q == TIMEOUT_V) ? wait_cnt_q
                                                       : wait_cnt_q + 1'b1;
            end else begin
                state_d = RUN;
            end
        end

        // Reset drives the front end into a flushed, non-advancing state.
        if (rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pipe_hold  = 1'b0;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (!pc_write),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (redirect_win),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_memread, ex_jump, ex_branch_taken;
    logic       mem_req, mem_ready;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold;
    logic [3:0] stall_count, flush_count;
    logic       mem_err;

    int n_assert = 0;
    int n_fail   = 0;

    // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}
    localparam logic [4:0] C_IDLE  = 5'b11000;
    localparam logic [4:0] C_RST   = 5'b00110;
    localparam logic [4:0] C_LU    = 5'b00010;
    localparam logic [4:0] C_REDIR = 5'b11110;
    localparam logic [4:0] C_HOLD  = 5'b00001;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .ex_jump         (ex_jump),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .pipe_hold       (pipe_hold),
        .stall_count     (stall_count),
        .flush_count     (flush_count),
        .mem_err         (mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        #1;
        chk(tag, {11'd0, pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}, {11'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_memread = 1'b0; ex_rt = 5'd0; ex_jump = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        chk_ctl("rst_ctl", C_RST);
        tick(); tick();
        chk("rst_stall", {12'd0, stall_count}, 16'd0);
        chk("rst_flush", {12'd0, flush_count}, 16'd0);
        chk("rst_err", {15'd0, mem_err}, 16'd0);
        rst = 1'b0;
        chk_ctl("idle", C_IDLE);
        tick();

        // load-use on rs: one-cycle stall
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        chk_ctl("lu_rs", C_LU);
        tick();
        chk("lu_stall1", {12'd0, stall_count}, 16'd1);
        ex_memread = 1'b0;
        chk_ctl("lu_bubble", C_IDLE);
        tick();
        chk("lu_stall1b", {12'd0, stall_count}, 16'd1);

        // $0 never stalls
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        chk_ctl("lu_zero", C_IDLE);
        tick();
        // rt match ignored unless rt is a source
        ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
        chk_ctl("lu_rt_unused", C_IDLE);
        tick();
        chk("lu_stall_still1", {12'd0, stall_count}, 16'd1);
        id_uses_rt = 1'b1;
        chk_ctl("lu_rt_used", C_LU);
        tick();
        chk("lu_stall2", {12'd0, stall_count}, 16'd2);
        idle_inputs();

        // redirect
        ex_branch_taken = 1'b1;
        chk_ctl("br_taken", C_REDIR);
        tick();
        chk("br_flush1", {12'd0, flush_count}, 16'd1);
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        chk_ctl("br_over_lu", C_REDIR);
        tick();
        chk("br_flush2", {12'd0, flush_count}, 16'd2);
        chk("br_no_stall", {12'd0, stall_count}, 16'd2);
        idle_inputs();
        ex_jump = 1'b1;
        chk_ctl("jump", C_REDIR);
        tick();
        chk("jump_flush3", {12'd0, flush_count}, 16'd3);
        idle_inputs();

        // memory wait: 3 hold cycles
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_ctl("mw_hold", C_HOLD);
            tick();
        end
        mem_ready = 1'b1;
        chk_ctl("mw_release", C_IDLE);
        tick();
        chk("mw_stall5", {12'd0, stall_count}, 16'd5);
        idle_inputs();

        // wait beats redirect; redirect fires on ready
        mem_req = 1'b1; ex_branch_taken = 1'b1;
        chk_ctl("mw_over_br", C_HOLD);
        tick();
        chk("mw_br_noflush", {12'd0, flush_count}, 16'd3);
        mem_ready = 1'b1;
        chk_ctl("mw_br_release", C_REDIR);
        tick();
        chk("mw_br_flush4", {12'd0, flush_count}, 16'd4);
        chk("mw_br_stall6", {12'd0, stall_count}, 16'd6);
        idle_inputs();
        // ready in the same cycle as req: no wait
        mem_req = 1'b1; mem_ready = 1'b1;
        chk_ctl("req_ready", C_IDLE);
        tick();
        chk("req_ready_stall", {12'd0, stall_count}, 16'd6);
        idle_inputs();

        // timeout: RUN cycle plus 4 MEM_WAIT cycles
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("to_not_yet", {15'd0, mem_err}, 16'd0);
        tick();
        chk("to_set", {15'd0, mem_err}, 16'd1);
        tick(); tick();
        chk("to_sticky", {15'd0, mem_err}, 16'd1);
        chk_ctl("to_still_hold", C_HOLD);
        chk("to_stall13", {12'd0, stall_count}, 16'd13);
        rst = 1'b1;
        chk_ctl("rst_mid_wait", C_RST);
        tick();
        rst = 1'b0; mem_req = 1'b0;
        chk("rst2_err", {15'd0, mem_err}, 16'd0);
        chk("rst2_stall", {12'd0, stall_count}, 16'd0);
        chk("rst2_flush", {12'd0, flush_count}, 16'd0);
        chk_ctl("rst2_idle", C_IDLE);
        tick();

        // stall counter saturation
        ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall", {12'd0, stall_count}, 16'd15);
        idle_inputs();

        // flush counter saturation
        ex_jump = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        chk("sat_flush", {12'd0, flush_count}, 16'd15);
        idle_inputs();
        chk_ctl("end_idle", C_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
